mux4_scan: RTL
==============

MUX4_SCAN -- requirements
Module: mux4_scan

Interface
REQ-001 SHALL have parameter DWELL, default 2, meaning the number of settle cycles per channel before sampling; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin one scan.
REQ-005 SHALL have port mask, input, 4, channel enables: bit0=a, bit1=b, bit2=c, bit3=d; latched on accepted start.
REQ-006 SHALL have port mux_out, input, 1, the output of the downstream 4:1 mux.
REQ-007 SHALL have port sel, output, 2, the select that drives the mux (00=a, 01=b, 10=c, 11=d).
REQ-008 SHALL have port sample, output, 4, captured mux_out per channel, where bit i belongs to channel i.
REQ-009 SHALL have port busy, output, 1, high while a scan is in progress.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse at the end of a scan.

Function
REQ-011 SHALL implement the states IDLE, SETTLE, CAPTURE and FINISH.
REQ-012 IDLE: SHALL accept start only here; start during SETTLE, CAPTURE or FINISH SHALL be ignored.
REQ-013 On accepted start with latched mask != 0, the block SHALL:
- set sel to the lowest enabled channel;
- clear the dwell counter;
- enter SETTLE next cycle.
REQ-014 On accepted start with mask == 0, the block SHALL:
- go directly to FINISH;
- leave sample unchanged;
- keep busy high for exactly that one FINISH cycle.
REQ-015 SETTLE: SHALL hold sel stable and increment the dwell counter each cycle; after DWELL cycles in SETTLE, the block SHALL enter CAPTURE.
REQ-016 CAPTURE (exactly one cycle): on that cycle's clock edge, the block SHALL write mux_out into sample[sel].
- Other sample bits SHALL be unchanged.
- Disabled channels SHALL never be written.
REQ-017 Leaving CAPTURE, if a higher-numbered enabled channel remains, the block SHALL:
- set sel to the next enabled channel, skipping disabled ones with no extra cycles;
- clear the dwell counter;
- return to SETTLE.
Otherwise the block SHALL enter FINISH.
REQ-018 FINISH (exactly one cycle): SHALL assert done, then return to IDLE.
REQ-019 Latency: for k enabled channels (k >= 1), the block SHALL take k*(DWELL+1)+1 cycles from the cycle after start to the done pulse.
REQ-020 busy SHALL be high in SETTLE, CAPTURE and FINISH, and low in IDLE.
REQ-021 done SHALL be high only in FINISH.
REQ-022 sel SHALL change only on SETTLE entry, and SHALL hold its last value in IDLE.
REQ-023 The dwell counter SHALL be 4 bits wide and SHALL not wrap within a channel.
REQ-024 sample SHALL hold its value across scans until overwritten.
REQ-025 Changes to mask after start is accepted SHALL have no effect on the current scan.
REQ-026 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-027 While rst_n is low, the block SHALL immediately, regardless of clk, force:
- state=IDLE;
- sel=00;
- sample=0000;
- busy=0;
- done=0;
- dwell counter=0.
REQ-028 Reset asserted mid-scan SHALL abort the scan with no done pulse; a start on the first clock edge after rst_n rises SHALL be accepted.

Verification
REQ-029 DWELL=2, mask=1111, mux_out driven as a(1) b(0) c(1) d(1) per sel -> sel sequence 00,01,10,11 (3 cycles each), sample=1101, done 13 cycles after start.
REQ-030 mask=1010, DWELL=2 -> sel visits only 01 then 11, sample bits 0 and 2 keep their prior values, done after 7 cycles.
REQ-031 mask=0000 -> busy high for 1 cycle, done 1 cycle after start, sample unchanged.
REQ-032 start pulsed again while busy, and mask changed mid-scan -> no restart, sequence and done timing identical to REQ-029.
REQ-033 rst_n pulled low during the SETTLE of channel c -> immediate sample=0000, busy=0, sel=00, no done; a new start after release completes normally.
REQ-034 Exhaustive check: all 16 mask values × all 16 mux_out patterns with DWELL=1 -> sample bit i = pattern bit i for every enabled i, and the error count reported is 0.

Source files
------------

// File: rtl/mux4_scan.sv
// Sequential scanner for a downstream 4:1 mux: steps sel across the enabled
// channels, lets each settle for DWELL cycles, then captures mux_out per channel.

module mux4_scan_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic wr,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= 1'b0;
    else if (wr) q <= d;
endmodule

module mux4_scan #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] sample,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, FINISH} state_t;

  state_t     state;
  logic [3:0] mask_q;
  logic [3:0] cnt;
  logic [1:0] first_sel, nxt_sel;
  logic       nxt_vld;

  // lowest enabled channel of the incoming mask
  always_comb begin
    first_sel = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (mask[i]) first_sel = 2'(i);
  end

  // next enabled channel strictly above the current one
  always_comb begin
    nxt_vld = 1'b0;
    nxt_sel = sel;
    for (int i = 3; i >= 0; i--)
      if (mask_q[i] && (3'(i) > {1'b0, sel})) begin
        nxt_vld = 1'b1;
        nxt_sel = 2'(i);
      end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= 2'd0;
      mask_q <= 4'd0;
      cnt    <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mask_q <= mask;
          cnt    <= 4'd0;
          busy   <= 1'b1;
          if (mask == 4'd0) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state <= SETTLE;
            sel   <= first_sel;
          end
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(DWELL - 1)) state <= CAPTURE;
        end
        CAPTURE: if (nxt_vld) begin
          sel   <= nxt_sel;
          cnt   <= 4'd0;
          state <= SETTLE;
        end else begin
          state <= FINISH;
          done  <= 1'b1;
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end

  // sel only ever lands on enabled channels, so disabled lanes are never written
  for (genvar g = 0; g < 4; g++) begin : g_lane
    mux4_scan_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    ((state == CAPTURE) && (sel == 2'(g))),
      .d     (mux_out),
      .q     (sample[g])
    );
  end
endmodule
